// File: rtl/cfg_stream_loader_if.sv
// Byte-stream handshake between the host-side byte source and cfg_stream_loader.
// The master presents s_data/s_valid; the loader answers with s_ready.
interface cfg_stream_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/cfg_stream_loader.sv
// Serial configuration loader: takes bytes over a valid/ready stream and shifts them LSB-first
// into the cluster programming chain. Optional build macro CFG_CRC_EN adds CRC check and readback CRC.
module cfg_stream_loader #(
  parameter int CHAIN_LEN = 168,
  parameter int CLK_DIV   = 2,
  parameter int CNT_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  cfg_stream_loader_if.slave  bus,
  output logic                prog_clk,
  output logic                prog_en,
  output logic                prog_in,
  input  logic                prog_out,
  output logic                busy,
  output logic                done,
  output logic                err
`ifdef CFG_CRC_EN
  ,
  output logic [7:0]          readback_crc
`endif
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CHAIN_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    SHIFT_LO,
    SHIFT_HI,
    DONE
`ifdef CFG_CRC_EN
    ,
    CRC_WAIT
`endif
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       byte_bits;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       shreg;

`ifdef CFG_CRC_EN
  logic [7:0] crc;

  // CRC-8, polynomial x^8+x^2+x+1, one bit per call, MSB-first register.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic b);
    logic fb;
    fb = c[7] ^ b;
    return {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
  endfunction
`else
  logic unused_prog_out;
  assign unused_prog_out = prog_out;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      byte_bits   <= '0;
      div_cnt     <= '0;
      shreg       <= '0;
      bus.s_ready <= 1'b0;
      prog_clk    <= 1'b0;
      prog_en     <= 1'b0;
      prog_in     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
`ifdef CFG_CRC_EN
      crc          <= '0;
      readback_crc <= '0;
`endif
    end else if (abort) begin
      // Abort wins over everything, including a coincident start.
      state       <= IDLE;
      div_cnt     <= '0;
      bus.s_ready <= 1'b0;
      prog_clk    <= 1'b0;
      prog_en     <= 1'b0;
      prog_in     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      if (busy) err <= 1'b1;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state       <= FETCH;
            err         <= 1'b0;
            bit_cnt     <= '0;
            div_cnt     <= '0;
            prog_en     <= 1'b1;
            bus.s_ready <= 1'b1;
            busy        <= 1'b1;
            done        <= 1'b0;
`ifdef CFG_CRC_EN
            crc          <= '0;
            readback_crc <= '0;
`endif
          end
        end

        FETCH: begin
          if (bus.s_valid && bus.s_ready) begin
            shreg       <= bus.s_data;
            byte_bits   <= '0;
            prog_in     <= bus.s_data[0];
            bus.s_ready <= 1'b0;
            div_cnt     <= '0;
            state       <= SHIFT_LO;
          end
        end

        SHIFT_LO: begin
          prog_in <= shreg[0];
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            prog_clk <= 1'b1;
            state    <= SHIFT_HI;
`ifdef CFG_CRC_EN
            // Chain output still shows the pre-shift bit on this edge.
            readback_crc <= crc8_step(readback_crc, prog_out);
`endif
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt   <= '0;
            prog_clk  <= 1'b0;
            bit_cnt   <= bit_cnt + 1'b1;
            byte_bits <= byte_bits + 1'b1;
            shreg     <= {1'b0, shreg[7:1]};
`ifdef CFG_CRC_EN
            crc <= crc8_step(crc, prog_in);
`endif
            if (bit_cnt == BIT_LAST) begin
`ifdef CFG_CRC_EN
              state       <= CRC_WAIT;
              bus.s_ready <= 1'b1;
`else
              state   <= DONE;
              prog_en <= 1'b0;
              prog_in <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end else if (byte_bits == 3'd7) begin
              state       <= FETCH;
              bus.s_ready <= 1'b1;
            end else begin
              // Next bit is launched together with the falling edge.
              state   <= SHIFT_LO;
              prog_in <= shreg[1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

`ifdef CFG_CRC_EN
        CRC_WAIT: begin
          if (bus.s_valid && bus.s_ready) begin
            if (bus.s_data != crc) err <= 1'b1;
            state       <= DONE;
            bus.s_ready <= 1'b0;
            prog_en     <= 1'b0;
            prog_in     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end
        end
`endif

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cfg_stream_loader.sv
// Self-checking bench for cfg_stream_loader: random byte streams against a bit-stream scoreboard,
// plus abort, start-while-busy and asynchronous reset scenarios.
`timescale 1ns/1ps
module tb_cfg_stream_loader;

  localparam int CL  = 20;
  localparam int DIV = 2;
  localparam int NB  = (CL + 7) / 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic prog_out = 1'b0;
  logic prog_clk, prog_en, prog_in, busy, done, err;

  cfg_stream_loader_if bus();

  always #5 clk = ~clk;

  cfg_stream_loader #(.CHAIN_LEN(CL), .CLK_DIV(DIV), .CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .bus      (bus),
    .prog_clk (prog_clk),
    .prog_en  (prog_en),
    .prog_in  (prog_in),
    .prog_out (prog_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] tx_q[$];
  bit         exp_q[$];
  int accepted   = 0;
  int edges      = 0;
  int stall_mode = 0;
  int stall_ctr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the chain sees the byte stream LSB-first, cut to CL bits.
  task automatic new_load(input int smode);
    logic [7:0] b;
    tx_q.delete();
    exp_q.delete();
    for (int i = 0; i < NB + 1; i++) begin
      b = 8'($urandom);
      tx_q.push_back(b);
    end
    for (int i = 0; i < CL; i++) begin
      b = tx_q[i / 8];
      exp_q.push_back(b[i % 8]);
    end
    accepted   = 0;
    edges      = 0;
    stall_mode = smode;
    stall_ctr  = 0;
  endtask

  // Stream driver
  initial begin : driver
    bit hs;
    bit stall;
    logic [7:0] junk;
    hs = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (hs && rst_n && tx_q.size() > 0) begin
        void'(tx_q.pop_front());
        accepted++;
        check("s_ready_drop", bus.s_ready, 0);
      end
      stall = 1'b0;
      if (stall_mode == 1) stall = ($urandom_range(0, 2) == 0);
      else if (stall_mode == 2 && accepted == 1 && stall_ctr < 20) begin
        stall = 1'b1;
        if (bus.s_ready) stall_ctr++;
      end
      if (tx_q.size() > 0 && !stall) begin
        bus.s_valid = 1'b1;
        bus.s_data  = tx_q[0];
      end else begin
        junk = 8'($urandom);
        bus.s_valid = 1'b0;
        bus.s_data  = junk;
      end
      hs = bus.s_valid && bus.s_ready && !abort && rst_n;
    end
  end

  // Chain-side monitor
  initial begin : monitor
    logic pc, pi;
    int hi_cnt, lo_cnt;
    pc = 1'b0; pi = 1'b0; hi_cnt = 0; lo_cnt = 1000;
    forever begin
      @(negedge clk);
      if (prog_clk && !pc) begin
        check("en_at_rise", prog_en, 1);
        if (prog_en) begin
          edges++;
          check("edge_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) check("prog_in_bit", prog_in, exp_q.pop_front());
          check("setup_cycles", lo_cnt >= DIV, 1);
        end
      end
      if (!prog_clk && pc && (prog_en || done)) check("high_cycles", hi_cnt, DIV);
      if (prog_clk && pc) check("in_stable_hi", prog_in, pi);
      if (bus.s_ready === 1'b1) begin
        check("stall_clk_low", prog_clk, 0);
        check("stall_en_high", prog_en, 1);
      end
      if (prog_clk) begin
        hi_cnt = pc ? hi_cnt + 1 : 1;
      end else begin
        lo_cnt = pc ? 1 : lo_cnt + 1;
      end
      pc = prog_clk;
      pi = prog_in;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_load(input int smode, input bit poke_start);
    int n;
    new_load(smode);
    pulse_start();
    check("busy_after_start", busy, 1);
    check("err_cleared", err, 0);
    check("en_after_start", prog_en, 1);
    check("done_cleared", done, 0);
    if (poke_start) begin
      repeat (15) tick();
      pulse_start();
      check("start_ignored_busy", busy, 1);
    end
    n = 0;
    while (!done && n < 2000) begin
      tick();
      n++;
    end
    check("done_in_time", done, 1);
    check("en_low_done", prog_en, 0);
    check("busy_low_done", busy, 0);
    check("err_done", err, 0);
    check("ready_low_done", bus.s_ready, 0);
    check("edge_count", edges, CL);
    check("bits_left", exp_q.size(), 0);
    repeat (4) tick();
    check("bytes_accepted", accepted, NB);
    check("done_held", done, 1);
  endtask

  initial begin : main
    int n;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_prog_clk", prog_clk, 0);
    check("rst_prog_en", prog_en, 0);
    check("rst_prog_in", prog_in, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_s_ready", bus.s_ready, 0);
    rst_n = 1'b1;
    tick();
    check("idle_busy", busy, 0);

    run_load(0, 1'b0);
    run_load(2, 1'b0);
    for (int i = 0; i < 4; i++) run_load(1, i == 1);

    // Abort from DONE: leaves, but no error since not busy.
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_done_clears", done, 0);
    check("abort_done_no_err", err, 0);

    abort = 1'b1; start = 1'b1; tick(); abort = 1'b0; start = 1'b0;
    check("abort_over_start", busy, 0);
    check("abort_over_start_en", prog_en, 0);

    // Abort after five shifted bits.
    new_load(1);
    pulse_start();
    n = 0;
    while (edges < 5 && n < 500) begin
      tick();
      n++;
    end
    check("reach_5_bits", edges, 5);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_en", prog_en, 0);
    check("abort_clk", prog_clk, 0);
    check("abort_err", err, 1);
    check("abort_ready", bus.s_ready, 0);
    repeat (3) tick();
    check("no_edges_after_abort", edges, 5);
    run_load(1, 1'b0);

    // Asynchronous reset while prog_clk is high.
    new_load(0);
    pulse_start();
    n = 0;
    while (!prog_clk && n < 500) begin
      tick();
      n++;
    end
    check("reach_shift_hi", prog_clk, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_clk", prog_clk, 0);
    check("async_rst_en", prog_en, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_ready", bus.s_ready, 0);
    tx_q.delete();
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_busy", busy, 0);
    check("post_rst_done", done, 0);
    run_load(0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
